// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported synchronous memory between instruction fetch (IF)
// and load/store (LS). In IDLE one requester is granted. Its ready is asserted
// combinationally in the same cycle and the memory access is issued at once.
// The block then waits MEM_LATENCY cycles and pulses the owning side's
// response with the read data. Stores return zero data.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   if_req_valid/ready        fetch request handshake
//   if_addr                   fetch byte address
//   if_resp_valid, if_rdata   fetch response pulse and data
//   ls_req_valid/ready        load/store request handshake
//   ls_we, ls_wstrb           store flag and byte enables
//   ls_addr, ls_wdata         load/store address and store data
//   ls_resp_valid, ls_rdata   load/store response pulse and data (0 on store)
//   mem_en, mem_we            memory strobe and byte write enables
//   mem_addr, mem_wdata       memory address and write data
//   mem_rdata                 memory read data, MEM_LATENCY cycles after mem_en
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [AW-1:0]   if_addr,
    output logic            if_resp_valid,
    output logic [DW-1:0]   if_rdata,
    input  logic            ls_req_valid,
    output logic            ls_req_ready,
    input  logic            ls_we,
    input  logic [DW/8-1:0] ls_wstrb,
    input  logic [AW-1:0]   ls_addr,
    input  logic [DW-1:0]   ls_wdata,
    output logic            ls_resp_valid,
    output logic [DW-1:0]   ls_rdata,
    output logic            mem_en,
    output logic [DW/8-1:0] mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int SW = DW / 8;
    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    // Owner / last encoding: 0 = IF, 1 = LS.
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;
    logic       owner_reg, owner_next;
    logic       store_reg, store_next;
    logic       last_reg, last_next;

    logic grant_if;
    logic grant_ls;
    logic resp_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
            owner_reg <= OWN_IF;
            store_reg <= 1'b0;
            last_reg  <= OWN_IF;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            owner_reg <= owner_next;
            store_reg <= store_next;
            last_reg  <= last_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        owner_next = owner_reg;
        store_next = store_reg;
        last_next  = last_reg;
        grant_if   = 1'b0;
        grant_ls   = 1'b0;
        resp_fire  = 1'b0;

        case (state_reg)
            IDLE: begin
                // Grants are suppressed during reset so that every output
                // reads zero while rst is high.
                if (!rst) begin
                    // LS wins when alone, or on conflict when IF went last.
                    if (ls_req_valid && (!if_req_valid || last_reg == OWN_IF)) begin
                        grant_ls = 1'b1;
                    end else if (if_req_valid) begin
                        grant_if = 1'b1;
                    end
                end
                if (grant_if || grant_ls) begin
                    owner_next = grant_ls ? OWN_LS : OWN_IF;
                    store_next = grant_ls && ls_we;
                    last_next  = grant_ls ? OWN_LS : OWN_IF;
                    cnt_next   = LAT;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 3'd1;
                if (cnt_reg == 3'd1) begin
                    resp_fire  = !rst;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign if_req_ready = grant_if;
    assign ls_req_ready = grant_ls;
    assign mem_en       = grant_if | grant_ls;
    assign mem_addr     = grant_ls ? ls_addr : (grant_if ? if_addr : '0);
    assign mem_wdata    = grant_ls ? ls_wdata : '0;

    // Byte write enables only when LS wins with a store.
    genvar gi;
    generate
        for (gi = 0; gi < SW; gi++) begin : g_we
            assign mem_we[gi] = grant_ls & ls_we & ls_wstrb[gi];
        end
    endgenerate

    assign if_resp_valid = resp_fire && (owner_reg == OWN_IF);
    assign ls_resp_valid = resp_fire && (owner_reg == OWN_LS);
    assign if_rdata      = (if_resp_valid && !store_reg) ? mem_rdata : '0;
    assign ls_rdata      = (ls_resp_valid && !store_reg) ? mem_rdata : '0;

endmodule
